// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared definitions for the data cache.
//   - controller state encodings
//   - FUNC3 access-type constants (loads and stores share 000/001/010)
//   - block and offset geometry
package data_cache_pkg;

    localparam int OFFSET_BITS = 4;    // 16-byte blocks
    localparam int BLOCK_BITS  = 128;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2,
        S_UPDATE    = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/data_cache_ctrl_fsm.sv
// dcache_ctrl_fsm: miss-handling controller for the data cache.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | serve hits; a miss picks WRITEBACK or ALLOCATE
// WRITEBACK | dirty victim block goes out to main memory
// ALLOCATE  | requested block is fetched from main memory
// UPDATE    | fetched block, tag and valid written into arrays
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req, hit          : CPU request present / request hits
//   victim_dirty      : indexed set is valid and dirty
//   mem_busywait      : main memory still busy
//   state             : current state (for the datapath)
//   busywait          : CPU stall
//   mem_read/mem_write: memory fetch / writeback request
//   fill_capture      : fetched block is on MEM_READDATA this cycle
//   fill_commit       : write captured block into the arrays
module dcache_ctrl_fsm
    import data_cache_pkg::*;
#(
    parameter int MEM_LATENCY_TOLERANT = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   req,
    input  logic   hit,
    input  logic   victim_dirty,
    input  logic   mem_busywait,
    output state_t state,
    output logic   busywait,
    output logic   mem_read,
    output logic   mem_write,
    output logic   fill_capture,
    output logic   fill_commit
);

    state_t next_state;
    logic   hold;

    // A latency-intolerant build assumes single-cycle memory and never waits.
    assign hold = mem_busywait && (MEM_LATENCY_TOLERANT != 0);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        busywait     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        fill_capture = 1'b0;
        fill_commit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req && !hit) begin
                    busywait   = 1'b1;
                    next_state = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                busywait  = 1'b1;
                mem_write = 1'b1;
                if (!hold) next_state = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (!hold) begin
                    fill_capture = 1'b1;
                    next_state   = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busywait    = 1'b1;
                fill_commit = 1'b1;
                next_state  = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // Reset abandons any transfer immediately, not just at the edge.
        if (reset) begin
            next_state   = S_IDLE;
            busywait     = req;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            fill_capture = 1'b0;
            fill_commit  = 1'b0;
        end
    end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache with
// 16-byte blocks and byte/halfword/word loads and stores.
//
// Ports:
//   CLK, RESET           : clock, synchronous active-high reset
//   READ_EN, WRITE_EN    : CPU load / store request (both = store)
//   FUNC3                : access type and load extension
//   ADDRESS, WRITE_DATA  : CPU byte address and store data
//   READ_DATA            : extended load result (held when idle)
//   BUSYWAIT             : CPU stall
//   MEM_READ, MEM_WRITE  : main-memory block fetch / writeback
//   MEM_ADDRESS          : block address to main memory
//   MEM_WRITEDATA        : victim block
//   MEM_READDATA         : fetched block
//   MEM_BUSYWAIT         : main memory not yet done
module data_cache
    import data_cache_pkg::*;
#(
    parameter int INDEX_BITS           = 3,
    parameter int MEM_LATENCY_TOLERANT = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ_EN,
    input  logic                  WRITE_EN,
    input  logic [2:0]            FUNC3,
    input  logic [31:0]           ADDRESS,
    input  logic [31:0]           WRITE_DATA,
    output logic [31:0]           READ_DATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [27:0]           MEM_ADDRESS,
    output logic [BLOCK_BITS-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_BITS-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;

    logic [BLOCK_BITS-1:0] data_array [SETS];
    logic [TAG_BITS-1:0]   tag_array  [SETS];
    logic [SETS-1:0]       valid;
    logic [SETS-1:0]       dirty;
    logic [BLOCK_BITS-1:0] fill_block;
    logic [31:0]           last_load;

    logic [INDEX_BITS-1:0]  index;
    logic [TAG_BITS-1:0]    tag;
    logic [OFFSET_BITS-1:0] offset;
    logic                   req, hit, victim_dirty, idle;
    logic                   load_done, store_commit;
    logic                   fill_capture, fill_commit;
    state_t                 state;

    logic [BLOCK_BITS-1:0] cur_block, new_block;
    logic [31:0]           word_sel, load_val;
    logic [15:0]           half_sel;
    logic [7:0]            byte_sel;

    assign offset = ADDRESS[OFFSET_BITS-1:0];
    assign index  = ADDRESS[OFFSET_BITS +: INDEX_BITS];
    assign tag    = ADDRESS[31 -: TAG_BITS];

    assign req          = READ_EN || WRITE_EN;
    assign hit          = req && valid[index] && (tag_array[index] == tag);
    assign victim_dirty = valid[index] && dirty[index];
    assign idle         = (state == S_IDLE);
    assign store_commit = idle && hit && WRITE_EN;
    assign load_done    = idle && hit && !WRITE_EN;

    dcache_ctrl_fsm #(
        .MEM_LATENCY_TOLERANT(MEM_LATENCY_TOLERANT)
    ) u_fsm (
        .clk          (CLK),
        .reset        (RESET),
        .req          (req),
        .hit          (hit),
        .victim_dirty (victim_dirty),
        .mem_busywait (MEM_BUSYWAIT),
        .state        (state),
        .busywait     (BUSYWAIT),
        .mem_read     (MEM_READ),
        .mem_write    (MEM_WRITE),
        .fill_capture (fill_capture),
        .fill_commit  (fill_commit)
    );

    // Sub-word selection aligns halfwords and words down by construction.
    assign cur_block = data_array[index];
    assign word_sel  = cur_block[{offset[3:2], 5'b0} +: 32];
    assign half_sel  = word_sel[{offset[1], 4'b0} +: 16];
    assign byte_sel  = word_sel[{offset[1:0], 3'b0} +: 8];

    always_comb begin
        load_val = word_sel;
        case (FUNC3)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_val = {24'b0, byte_sel};
            F3_HU:   load_val = {16'b0, half_sel};
            default: load_val = word_sel;
        endcase
    end

    always_comb begin
        new_block = cur_block;
        case (FUNC3)
            F3_B:    new_block[{offset, 3'b0} +: 8]        = WRITE_DATA[7:0];
            F3_H:    new_block[{offset[3:1], 4'b0} +: 16]  = WRITE_DATA[15:0];
            default: new_block[{offset[3:2], 5'b0} +: 32]  = WRITE_DATA;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid     <= '0;
            dirty     <= '0;
            last_load <= '0;
        end else begin
            if (fill_commit) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end else if (store_commit) begin
                dirty[index] <= 1'b1;
            end
            if (load_done) last_load <= load_val;
        end
    end

    // Arrays carry no reset; valid bits qualify their contents.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (fill_capture) fill_block <= MEM_READDATA;
            if (fill_commit) begin
                data_array[index] <= fill_block;
                tag_array[index]  <= tag;
            end else if (store_commit) begin
                data_array[index] <= new_block;
            end
        end
    end

    assign READ_DATA     = RESET ? 32'b0 : (load_done ? load_val : last_load);
    assign MEM_ADDRESS   = MEM_WRITE ? {tag_array[index], index} :
                           MEM_READ  ? ADDRESS[31:4] : 28'b0;
    assign MEM_WRITEDATA = MEM_WRITE ? cur_block : '0;

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         READ_EN, WRITE_EN;
    logic [2:0]   FUNC3;
    logic [31:0]  ADDRESS, WRITE_DATA, READ_DATA;
    logic         BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA, MEM_READDATA;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    data_cache #(.INDEX_BITS(3), .MEM_LATENCY_TOLERANT(1)) dut (
        .CLK(CLK), .RESET(RESET), .READ_EN(READ_EN), .WRITE_EN(WRITE_EN),
        .FUNC3(FUNC3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    // Memory model: 5 busy cycles then one done cycle per transfer.
    logic [127:0] mem [256];
    logic         mem_init;
    int           busy_cnt;

    function automatic logic [127:0] init_block(input int i);
        logic [31:0] base;
        base = 32'hA000_0000 | (i << 8);
        if (i == 4) return {base | 3, base | 2, base | 1, 32'hDEADBEEF};
        return {base | 3, base | 2, base | 1, base};
    endfunction

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (busy_cnt < 5);
    assign MEM_READDATA = mem[MEM_ADDRESS[7:0]];

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_block(i);
            busy_cnt <= 0;
        end else begin
            if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS[7:0]] <= MEM_WRITEDATA;
            if ((MEM_READ || MEM_WRITE) && MEM_BUSYWAIT) busy_cnt <= busy_cnt + 1;
            else busy_cnt <= 0;
        end
    end

    int           rd_cyc = 0, wr_cyc = 0, both_cnt = 0;
    logic [27:0]  rd_addr, wr_addr;
    logic [127:0] wr_data;

    always @(negedge CLK) begin
        #2;
        if (MEM_READ)  begin rd_cyc++; rd_addr = MEM_ADDRESS; end
        if (MEM_WRITE) begin wr_cyc++; wr_addr = MEM_ADDRESS; wr_data = MEM_WRITEDATA; end
        if (MEM_READ && MEM_WRITE) both_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output int stalls);
        stalls = 0;
        while (BUSYWAIT !== 1'b0 && stalls < 300) begin
            @(negedge CLK); #1;
            stalls++;
        end
        if (stalls >= 300) chk("busywait_timeout", stalls, 0);
    endtask

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int stalls, output logic [31:0] rdata);
        @(negedge CLK);
        READ_EN = rd; WRITE_EN = wr; FUNC3 = f3; ADDRESS = a; WRITE_DATA = wd;
        #1;
        wait_ready(stalls);
        rdata = READ_DATA;
        @(posedge CLK); #1;
        READ_EN = 1'b0; WRITE_EN = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int          st, rc0, wc0;
        logic [31:0] rd;

        RESET = 1'b1; mem_init = 1'b1;
        READ_EN = 1'b0; WRITE_EN = 1'b0; FUNC3 = 3'b010;
        ADDRESS = 32'h0; WRITE_DATA = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        chk("rst_busywait", BUSYWAIT, 1'b0);
        chk("rst_mem_read", MEM_READ, 1'b0);
        chk("rst_mem_write", MEM_WRITE, 1'b0);
        chk("rst_read_data", READ_DATA, 32'h0);
        chk("rst_mem_addr", MEM_ADDRESS, 28'h0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 128'h0);
        @(negedge CLK);
        RESET = 1'b0; mem_init = 1'b0;
        #1;
        chk("post_rst_busywait", BUSYWAIT, 1'b0);
        chk("post_rst_read_data", READ_DATA, 32'h0);

        // Cold miss on LW 0x40
        rc0 = rd_cyc; wc0 = wr_cyc;
        access(1, 0, 3'b010, 32'h40, 0, st, rd);
        chk("lw40_stalls", st, 8);
        chk("lw40_data", rd, 32'hDEADBEEF);
        chk("lw40_rd_cycles", rd_cyc - rc0, 6);
        chk("lw40_rd_addr", rd_addr, 28'h0000004);
        chk("lw40_wr_cycles", wr_cyc - wc0, 0);
        @(negedge CLK); #1;
        chk("idle_hold_data", READ_DATA, 32'hDEADBEEF);
        chk("idle_busywait", BUSYWAIT, 1'b0);

        // Byte store / signed and unsigned byte loads
        access(0, 1, 3'b000, 32'h41, 32'h80, st, rd);
        chk("sb41_stalls", st, 0);
        access(1, 0, 3'b000, 32'h41, 0, st, rd);
        chk("lb41_stalls", st, 0);
        chk("lb41_data", rd, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h41, 0, st, rd);
        chk("lbu41_data", rd, 32'h00000080);
        access(1, 0, 3'b010, 32'h40, 0, st, rd);
        chk("lw40_after_sb", rd, 32'hDEAD80EF);

        // Halfword store/loads, misaligned addresses aligned down
        access(0, 1, 3'b001, 32'h46, 32'h1234, st, rd);
        chk("sh46_stalls", st, 0);
        access(1, 0, 3'b101, 32'h47, 0, st, rd);
        chk("lhu47_data", rd, 32'h00001234);
        access(1, 0, 3'b010, 32'h45, 0, st, rd);
        chk("lw45_aligned", rd, 32'h12340401);
        access(1, 0, 3'b001, 32'h42, 0, st, rd);
        chk("lh42_data", rd, 32'hFFFFDEAD);
        access(1, 0, 3'b101, 32'h42, 0, st, rd);
        chk("lhu42_data", rd, 32'h0000DEAD);
        access(1, 0, 3'b010, 32'h48, 0, st, rd);
        chk("lw48_untouched", rd, 32'hA0000402);

        // READ_EN and WRITE_EN together act as a store
        access(1, 1, 3'b010, 32'h40, 32'h55, st, rd);
        chk("rw40_stalls", st, 0);
        access(1, 0, 3'b010, 32'h40, 0, st, rd);
        chk("lw40_after_rw", rd, 32'h00000055);

        // Dirty victim in set 2, then conflicting tag
        access(0, 1, 3'b010, 32'h20, 32'hCAFEF00D, st, rd);
        chk("sw20_stalls", st, 8);
        rc0 = rd_cyc; wc0 = wr_cyc;
        access(1, 0, 3'b010, 32'h120, 0, st, rd);
        chk("lw120_stalls", st, 14);
        chk("lw120_data", rd, 32'hA0001200);
        chk("lw120_wr_cycles", wr_cyc - wc0, 6);
        chk("lw120_wr_addr", wr_addr, 28'h0000002);
        chk("lw120_wr_data", wr_data, {32'hA0000203, 32'hA0000202, 32'hA0000201, 32'hCAFEF00D});
        chk("lw120_rd_cycles", rd_cyc - rc0, 6);
        chk("lw120_rd_addr", rd_addr, 28'h0000012);
        wc0 = wr_cyc;
        access(1, 0, 3'b010, 32'h20, 0, st, rd);
        chk("lw20_refetch_stalls", st, 8);
        chk("lw20_refetch_data", rd, 32'hCAFEF00D);
        chk("lw20_no_writeback", wr_cyc - wc0, 0);

        // Reset in the 3rd ALLOCATE cycle
        @(negedge CLK);
        READ_EN = 1'b1; WRITE_EN = 1'b0; FUNC3 = 3'b010; ADDRESS = 32'h200;
        repeat (3) @(negedge CLK);
        #1;
        chk("alloc3_mem_read", MEM_READ, 1'b1);
        RESET = 1'b1;
        #1;
        chk("in_rst_mem_read", MEM_READ, 1'b0);
        chk("in_rst_busywait", BUSYWAIT, 1'b1);
        chk("in_rst_read_data", READ_DATA, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("after_rst_mem_read", MEM_READ, 1'b0);
        chk("after_rst_mem_addr", MEM_ADDRESS, 28'h0);
        chk("after_rst_read_data", READ_DATA, 32'h0);
        chk("after_rst_busywait", BUSYWAIT, 1'b1);
        wait_ready(st);
        chk("lw200_remiss_stalls", st, 8);
        chk("lw200_data", READ_DATA, 32'hA0002000);
        @(posedge CLK); #1;
        READ_EN = 1'b0;

        // Dirty data in set 4 was dropped by reset: clean miss, memory original
        wc0 = wr_cyc;
        access(1, 0, 3'b010, 32'h40, 0, st, rd);
        chk("lw40_post_rst_stalls", st, 8);
        chk("lw40_post_rst_no_wb", wr_cyc - wc0, 0);
        chk("lw40_post_rst_data", rd, 32'hDEADBEEF);

        chk("mem_rw_exclusive", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 3, meaning log2 of the number of direct-mapped sets (8 sets).
REQ-002 The block SHALL have parameter MEM_LATENCY_TOLERANT, default 1, meaning that the memory busywait can be held for any number of cycles.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port READ_EN, input, 1, CPU load request.
REQ-006 The block SHALL have port WRITE_EN, input, 1, CPU store request.
REQ-007 The block SHALL have port FUNC3, input, 3, access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 000/001/010 SB/SH/SW.
REQ-008 The block SHALL have port ADDRESS, input, 32, CPU byte address.
REQ-009 The block SHALL have port WRITE_DATA, input, 32, store data in the low bits.
REQ-010 The block SHALL have port READ_DATA, output, 32, extended load result.
REQ-011 The block SHALL have port BUSYWAIT, output, 1, stall to the CPU pipeline (MEM_BUSYWAIT).
REQ-012 The block SHALL have port MEM_READ, output, 1, main-memory block fetch request.
REQ-013 The block SHALL have port MEM_WRITE, output, 1, main-memory block writeback request.
REQ-014 The block SHALL have port MEM_ADDRESS, output, 28, block address (ADDRESS[31:4]).
REQ-015 The block SHALL have port MEM_WRITEDATA, output, 128, victim block.
REQ-016 The block SHALL have port MEM_READDATA, input, 128, fetched block.
REQ-017 The block SHALL have port MEM_BUSYWAIT, input, 1, main memory not yet done.

Function
REQ-018 The cache SHALL be direct-mapped, write-back and write-allocate, with 16-byte blocks: offset=ADDRESS[3:0], index=ADDRESS[4+INDEX_BITS-1:4], tag=remaining upper bits, plus a valid bit and a dirty bit per set.
REQ-019 A hit SHALL be defined as READ_EN|WRITE_EN, valid[index] set, and tag match, evaluated combinationally.
REQ-020 The FSM SHALL have states IDLE, WRITEBACK, ALLOCATE and UPDATE.
REQ-021 In IDLE, on a hit: BUSYWAIT=0 the same cycle; READ_DATA is combinational; a store is committed at the next edge and sets dirty.
REQ-022 In IDLE, on a miss with dirty victim, the FSM SHALL go to WRITEBACK; on a miss with clean or invalid victim, it SHALL go to ALLOCATE.
REQ-023 In WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={victim tag,index}, MEM_WRITEDATA=victim block; the state SHALL be held while MEM_BUSYWAIT=1 and then go to ALLOCATE.
REQ-024 In ALLOCATE: MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4]; the state SHALL be held while MEM_BUSYWAIT=1 and then go to UPDATE.
REQ-025 In UPDATE, the block, tag and valid=1 SHALL be written with dirty=0, then the FSM SHALL go to IDLE, where the access completes as a hit (REQ-021).
REQ-026 BUSYWAIT SHALL equal 1 whenever a request is pending and not hitting in IDLE, and in every non-IDLE state.
REQ-027 The miss penalty SHALL be (writeback cycles if dirty) + fetch cycles + 1 UPDATE + 1 hit cycle.
REQ-028 Load extension: LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the selected byte/halfword; LW returns the whole word.
REQ-029 Misaligned halfword/word accesses SHALL be aligned down (ADDRESS[0] is ignored for H; ADDRESS[1:0] is ignored for W); no exception is raised.
REQ-030 Stores SHALL update only the addressed byte, halfword or word lanes.
REQ-031 If READ_EN and WRITE_EN are both 1, the access SHALL be treated as a store.
REQ-032 With no request, BUSYWAIT=0 and READ_DATA SHALL hold its last value (no X).
REQ-033 MEM_READ and MEM_WRITE SHALL never both be 1.
REQ-034 The CPU SHALL hold ADDRESS, FUNC3 and data stable while BUSYWAIT=1; the block does not latch them.

Reset
REQ-035 When RESET=1 at a rising edge, the state SHALL become IDLE and all valid and dirty bits SHALL be cleared, even in the middle of a WRITEBACK or ALLOCATE; the pending transfer is abandoned.
REQ-036 During reset and the cycle after it: MEM_READ=0, MEM_WRITE=0, BUSYWAIT=0 unless a request is present, READ_DATA=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
REQ-037 Data and tag arrays SHALL NOT need to be cleared on reset.

Structure
REQ-038 The shared package/header SHALL hold the FSM state encodings, the FUNC3 access-type constants, and the block/offset widths.
REQ-039 There SHALL be one sub-module, dcache_ctrl_fsm, that holds the state register, next-state logic and MEM_READ/MEM_WRITE/BUSYWAIT decode; the arrays and the lane/extension logic stay in data_cache.

Verification
REQ-040 Scenario: after reset, LW 0x00000040, where memory returns 0x...DEADBEEF in word 0 after 5 busy cycles -> ALLOCATE 5+1 cycles, UPDATE 1, then READ_DATA=0xDEADBEEF and BUSYWAIT falls.
REQ-041 Scenario: SB 0x41 with data 0x80, then LB 0x41 -> both are hits with BUSYWAIT=0; LB returns 0xFFFFFF80 and LBU returns 0x00000080.
REQ-042 Scenario: a dirty set 2 (address 0x20), then LW 0x120 (same index, new tag) -> MEM_WRITE with MEM_ADDRESS=0x0000002 and dirty data, then MEM_READ with MEM_ADDRESS=0x0000012, then a hit.
REQ-043 Scenario: SH 0x46 with data 0x1234 and LHU 0x47 -> aligned down, returns 0x00001234; the other lanes are unchanged.
REQ-044 Scenario: RESET asserted during the 3rd cycle of ALLOCATE -> next cycle MEM_READ=0 and state IDLE; a re-access to the same address misses again.
REQ-045 Scenario: READ_EN=WRITE_EN=1 on address 0x40 with data 0x55 -> performed as SW; a later LW 0x40 returns 0x00000055.
